// File: rtl/gelato_queue_arbiter_if.sv
// Bundle between gelato_queue_arbiter and its queue bank and downstream consumer:
// per-queue read ports (empty/tail/mask/pop) plus the registered output handshake.
interface gelato_queue_arbiter_if #(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 32,
    parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
);
    logic [NUM_QUEUES-1:0]                 q_empty;
    logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0] q_data;
    logic [NUM_QUEUES-1:0]                 q_mask;
    logic [NUM_QUEUES-1:0]                 q_pop;
    logic                                  out_valid;
    logic [DATA_WIDTH-1:0]                 out_data;
    logic [QID_WIDTH-1:0]                  out_qid;
    logic                                  out_ready;

    modport master (
        output q_empty, q_data, q_mask, out_ready,
        input  q_pop, out_valid, out_data, out_qid
    );

    modport slave (
        input  q_empty, q_data, q_mask, out_ready,
        output q_pop, out_valid, out_data, out_qid
    );
endinterface

// File: rtl/gelato_queue_arbiter.sv
// Round-robin read-side arbiter over a bank of gelato_queue instances, popping one
// eligible queue per cycle into a single registered valid/ready output stage.
module gelato_queue_arbiter #(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 32,
    parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    gelato_queue_arbiter_if.slave bus
);
    localparam logic [QID_WIDTH-1:0] LAST_QID = QID_WIDTH'(NUM_QUEUES - 1);

    logic [NUM_QUEUES-1:0] elig_s;
    logic [NUM_QUEUES-1:0] q_pop_s;
    logic [QID_WIDTH:0]    pick_s;
    logic [QID_WIDTH-1:0]  grant_s;
    logic                  found_s;
    logic                  load_s;
    logic [QID_WIDTH-1:0]  last_grant_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [QID_WIDTH-1:0]  out_qid_r;

    // Returns {found, index}; scanning offsets downward lets the nearest eligible index win.
    function automatic logic [QID_WIDTH:0] rr_pick(input logic [NUM_QUEUES-1:0] elig,
                                                   input logic [QID_WIDTH-1:0]  last);
        logic [QID_WIDTH:0]   pick;
        logic [QID_WIDTH-1:0] sel;
        int                   idx;
        pick = {(QID_WIDTH + 1){1'b0}};
        for (int k = NUM_QUEUES; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_QUEUES;
            sel = QID_WIDTH'(idx);
            if (elig[sel]) begin
                pick = {1'b1, sel};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign elig_s  = ~bus.q_empty & ~bus.q_mask;
    assign pick_s  = rr_pick(elig_s, last_grant_r);
    assign found_s = pick_s[QID_WIDTH];
    assign grant_s = pick_s[QID_WIDTH-1:0];
    // rst_n gates the load so no pop escapes while the bank is being reset.
    assign load_s  = rst_n & rdy & found_s & (~out_valid_r | bus.out_ready);

    // One-hot pop strobe to the granted queue, zero when not loading.
    always_comb begin
        q_pop_s = {NUM_QUEUES{1'b0}};
        if (load_s) begin
            q_pop_s[grant_s] = 1'b1;
        end else begin
            q_pop_s = {NUM_QUEUES{1'b0}};
        end
    end

    // Output stage and round-robin pointer; a load takes priority over a plain accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_WIDTH{1'b0}};
            out_qid_r    <= {QID_WIDTH{1'b0}};
            last_grant_r <= LAST_QID;
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= bus.q_data[grant_s];
            out_qid_r    <= grant_s;
            last_grant_r <= grant_s;
        end else if (rdy && out_valid_r && bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign bus.q_pop     = q_pop_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_qid   = out_qid_r;
endmodule

// File: doc/gelato_queue_arbiter.md
# gelato_queue_arbiter

Read-side consumer for a bank of `gelato_queue` instances. It watches NUM_QUEUES queue read ports (empty flag plus tail data) and selects one non-empty, unmasked queue per cycle in round-robin order. It pops that queue and registers the entry into a single output stage with a valid/ready handshake. It sits between the per-warp instruction/request queues and the downstream issue or execution unit.

## Interface
- NUM_QUEUES, default 4: number of queue read ports; ≥2.
- DATA_WIDTH, default 32: width of one queue entry.
- QID_WIDTH, default $clog2(NUM_QUEUES): width of the queue index.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable. When low, all state holds, q_pop is all-zero and outputs keep their values.
- q_empty  in  NUM_QUEUES  per-queue empty flag from the queue.
- q_data  in  NUM_QUEUES×DATA_WIDTH  per-queue tail data, combinational from the queue.
- q_mask  in  NUM_QUEUES  1 = queue ineligible this cycle (e.g. warp stalled).
- q_pop  out  NUM_QUEUES  one-hot or zero; pop strobe to the queue.
- out_valid  out  1  output stage holds an entry.
- out_data  out  DATA_WIDTH  registered entry.
- out_qid  out  QID_WIDTH  index of the queue the entry came from.
- out_ready  in  1  downstream accepts when out_valid && out_ready.

## Operation
- Eligible set: `elig[i] = !q_empty[i] && !q_mask[i]`.
- Load condition: `load = rdy && |elig && (!out_valid || out_ready)`.
- Grant: the first eligible index searching upward from `(last_grant+1) mod NUM_QUEUES` and wrapping.
- `q_pop[grant] = load`. All other bits are 0. q_pop is combinational from registered state and inputs. It is forced to 0 while rst_n is low.
- On a load edge:
  - out_data ← q_data[grant]
  - out_qid ← grant
  - out_valid ← 1
  - last_grant ← grant
- On an edge with rdy && out_valid && out_ready && !load: out_valid ← 0. out_data and out_qid hold their stale values.
- Simultaneous accept and load: the output is replaced in the same edge. This gives full throughput of 1 entry/cycle.
- Output stalled (out_valid && !out_ready):
  - no pop.
  - out_data and out_qid are stable.
  - last_grant is unchanged.
- last_grant advances only on a load. A masked or empty queue never consumes a turn.
- Only one queue is eligible: it is granted on every load, regardless of last_grant.
- rdy low: no pop, no register update, and the handshake is not considered. Downstream must not treat out_valid && out_ready as a transfer while rdy is low.

## Timing
- Reset values:
  - out_valid = 0
  - out_data = 0
  - out_qid = 0
  - last_grant = NUM_QUEUES−1, so queue 0 has first priority
  - q_pop = 0
- Pop-to-output latency: 1 cycle. Data sampled at edge N (q_pop high in cycle N−1) is visible on out_data after edge N. The queue advances its tail on the same edge.
- q_pop depends combinationally on q_empty, q_mask and out_ready in the same cycle. There is no combinational path from q_data to q_pop.
- Reset mid-operation: the held entry is dropped (out_valid → 0 asynchronously). The popped entry is lost. The queues are expected to be reset together.
- Wrap-around: the search from last_grant = NUM_QUEUES−1 starts at index 0.

## Test plan
- Reset, then queue 2 alone non-empty with tail 0xA5A5_0002 and out_ready=1 → q_pop=4'b0100 in cycle 0. Next cycle: out_valid=1, out_data=0xA5A5_0002, out_qid=2.
- All 4 queues hold 3 entries, out_ready=1 constant → grant order 0,1,2,3,0,1,2,3,0,1,2,3. One pop per cycle, 12 consecutive valid cycles, then out_valid drops.
- All queues non-empty, out_ready=0 for 5 cycles after the first load → q_pop stays 0. out_data and out_qid are held for all 5 cycles. After out_ready=1, the next grant is (previous qid+1).
- All queues non-empty, q_mask=4'b0010 → queue 1 is never popped. Order is 0,2,3,0,2,3. Clearing the mask after grant 3 → next grant is 0, then 1.
- rdy=0 for 3 cycles with a pending entry and out_ready=1 → no q_pop. out_valid, out_data and last_grant are unchanged. Resuming rdy=1 completes the transfer.
- Assert rst_n=0 while out_valid=1 → out_valid=0 and q_pop=0 immediately. After release, the first grant is queue 0.
